// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and common constants.
package pipeline_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold has priority, then load, otherwise insert a bubble.
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // A bubble clears instruction and valid but leaves PCPlus4D as it was.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (!hold) begin
            if (load) begin
                instr_d    = instr_in;
                pc_plus4_d = pc_plus4_in;
                valid_d    = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_plus4_out = pc_plus4_q;
    assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect FSM that discards stale memory responses,
// and the IF/ID register.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  redir_q, redir_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  br_target;
    logic         br;
    logic         load_id;

    assign br        = PCSrcD & ~StallD;
    assign br_target = PCBranchD & ~32'h3;
    assign pc_plus4  = pcf_q + 32'd4;

    // A redirect arriving while a request is outstanding cannot cancel it, so the
    // target is parked in RedirPC until the stale response has been consumed.
    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        redir_d = redir_q;
        case (state_q)
            ST_REQ: begin
                if (ImemReady) begin
                    pcf_d = br ? br_target : (StallF ? pcf_q : pc_plus4);
                end else if (br) begin
                    redir_d = br_target;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (br) redir_d = br_target;
                if (ImemReady) begin
                    pcf_d   = br ? br_target : redir_q;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pcf_q   <= RESET_PC;
            redir_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            redir_q <= redir_d;
        end
    end

    assign ImemReq   = rst_n;
    assign ImemAddr  = pcf_q;
    assign FetchBusy = (state_q == ST_DROP) | (ImemReq & ~ImemReady);
    assign load_id   = (state_q == ST_REQ) & ImemReady & ~br;

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (StallD),
        .load         (load_id),
        .instr_in     (ImemRdata),
        .pc_plus4_in  (pc_plus4),
        .instr_out    (InstrD),
        .pc_plus4_out (PCPlus4D),
        .valid_out    (ValidD)
    );

endmodule
